// File: rtl/detector_arbiter.sv
// Round-robin arbiter feeding one captured request word, LSB first, through a
// three-state Moore detector; counts cycles whose next detector state is B or C.
// Fixed latency: grant on the request edge, done pulse DATA_W edges later, idle one edge after.
module detector_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_W-1:0]       data_in,
  output logic [N_REQ-1:0]              gnt,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(N_REQ)-1:0]      done_id,
  output logic [$clog2(DATA_W+1)-1:0]   match_cnt,
  output logic                          det_z
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} ctl_state_t;
  typedef enum logic [1:0] {DET_A = 2'd0, DET_B = 2'd1, DET_C = 2'd2} det_state_t;

  ctl_state_t        state, state_nxt;
  det_state_t        det, det_nxt;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] sel_word;
  logic [CW-1:0]     bit_idx;
  logic [IDW-1:0]    last_grant;
  logic [IDW-1:0]    pick;
  logic              any_req;

  assign any_req = |req;

  // Round-robin search upward from the requester after the last one served.
  always_comb begin
    int cand;
    logic found;
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req[IDW'(cand)]) begin
        pick  = IDW'(cand);
        found = 1'b1;
      end
    end
  end

  // Select the chosen requester's word for capture.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IDW'(i)) sel_word = data_in[i*DATA_W +: DATA_W];
    end
  end

  // Moore detector transition; the captured word is shifted so bit 0 is always current.
  always_comb begin
    det_nxt = det;
    case (det)
      DET_A:   det_nxt = word[0] ? DET_B : DET_A;
      DET_B:   det_nxt = word[0] ? DET_C : DET_A;
      DET_C:   det_nxt = word[0] ? DET_A : DET_C;
      default: det_nxt = DET_A;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Controller next-state: SHIFT runs for exactly DATA_W edges.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SHIFT;
      SHIFT:   if (bit_idx == CW'(DATA_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Controller outputs decoded from state; detector output decoded from its state.
  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    det_z = (det == DET_B) || (det == DET_C);
  end

  // Datapath: capture on grant, shift/count in SHIFT, clear everything on leaving DONE
  // so IDLE presents all-zero outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= '0;
      word       <= '0;
      det        <= DET_A;
      match_cnt  <= '0;
      bit_idx    <= '0;
      done_id    <= '0;
      last_grant <= IDW'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= N_REQ'(1) << pick;
            word      <= sel_word;
            det       <= DET_A;
            match_cnt <= '0;
            bit_idx   <= '0;
            done_id   <= pick;
          end
        end
        SHIFT: begin
          det     <= det_nxt;
          word    <= word >> 1;
          bit_idx <= bit_idx + CW'(1);
          if ((det_nxt != DET_A) && (match_cnt != CW'(DATA_W)))
            match_cnt <= match_cnt + CW'(1);
        end
        DONE: begin
          gnt        <= '0;
          last_grant <= done_id;
          det        <= DET_A;
          match_cnt  <= '0;
          bit_idx    <= '0;
          done_id    <= '0;
        end
        default: begin
          gnt <= '0;
          det <= DET_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_detector_arbiter.sv
// Directed bench for detector_arbiter with N_REQ=4, DATA_W=8.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_detector_arbiter;

  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;

  logic                        clk;
  logic                        rst;
  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_W-1:0]     data_in;
  logic [N_REQ-1:0]            gnt;
  logic                        busy;
  logic                        done;
  logic [1:0]                  done_id;
  logic [3:0]                  match_cnt;
  logic                        det_z;

  int checks   = 0;
  int failures = 0;

  detector_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt),
    .det_z     (det_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},   32'(gnt), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_id"},    32'(done_id), 0);
    check({tag, "_cnt"},   32'(match_cnt), 0);
    check({tag, "_detz"},  32'(det_z), 0);
  endtask

  // One full service: present r/words, after the grant edge drop req and swap data
  // to alt_words; expect done after DATA_W more edges with the given id and count.
  task automatic service(input string tag, input logic [3:0] r, input logic [31:0] words,
                         input logic [31:0] alt_words, input int exp_id, input int exp_cnt);
    int n;
    int gcnt;
    int dcnt;
    logic [3:0] oh;
    oh = 4'(1 << exp_id);
    req = r;
    data_in = words;
    tick();
    check({tag, "_gnt"}, 32'(gnt), 32'(oh));
    check({tag, "_busy"}, 32'(busy), 1);
    req = '0;
    data_in = alt_words;
    n = 0;
    gcnt = 1;
    dcnt = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (gnt === oh) gcnt++;
    end
    check({tag, "_lat"}, 32'(n), DATA_W);
    check({tag, "_id"}, 32'(done_id), 32'(exp_id));
    check({tag, "_cnt"}, 32'(match_cnt), 32'(exp_cnt));
    check({tag, "_gntcyc"}, 32'(gcnt), DATA_W + 1);
    if (done === 1'b1) dcnt++;
    tick();
    if (done === 1'b1) dcnt++;
    check({tag, "_pulses"}, 32'(dcnt), 1);
    check_idle({tag, "_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gidx[$];
    int gcyc[$];
    logic [3:0] prev;
    int n;
    int dseen;

    rst = 1'b1;
    req = '0;
    data_in = '0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("idle_noreq");

    // Single requests: words 00 -> 0, FF -> 6, 03 -> 8 detections.
    service("s0", 4'b0001, 32'h0000_0000, 32'h0000_0000, 0, 0);
    service("s1", 4'b0010, 32'h0000_FF00, 32'h0000_FF00, 1, 6);
    service("s2", 4'b0100, 32'h0003_0000, 32'h0003_0000, 2, 8);

    // Fairness after reset with all requests held.
    do_reset();
    req = 4'b1111;
    data_in = 32'h00_03_FF_00;
    prev = '0;
    for (int c = 0; c < 45; c++) begin
      tick();
      check("onehot", 32'($onehot0(gnt)), 1);
      if (prev == 0 && gnt != 0) begin
        gidx.push_back($clog2(gnt));
        gcyc.push_back(c);
      end
      prev = gnt;
    end
    check("fair_n", 32'(gidx.size()), 5);
    if (gidx.size() == 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("fair_id%0d", i), 32'(gidx[i]), 32'(i % 4));
      for (int i = 1; i < 5; i++) check($sformatf("fair_per%0d", i), 32'(gcyc[i] - gcyc[i-1]), 10);
    end

    // Reset in the 4th SHIFT cycle of a word0 service.
    do_reset();
    req = 4'b1111;
    data_in = 32'h0000_00FF;
    tick();
    check("mid_gnt", 32'(gnt), 32'h1);
    check("mid_detz0", 32'(det_z), 0);
    tick();
    check("mid_detz1", 32'(det_z), 1);
    tick();
    tick();
    check("mid_detz3", 32'(det_z), 0);
    check("mid_cnt3", 32'(match_cnt), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_rst");
    tick();
    check("mid_regnt", 32'(gnt), 32'h1);
    req = '0;
    dseen = 0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      tick();
      n++;
      if (done === 1'b1) dseen++;
    end
    check("mid_drain", 32'(busy), 0);
    check("mid_done1", 32'(dseen), 1);

    // Req drops and data changes during SHIFT: captured 03 still yields 8.
    do_reset();
    service("chg", 4'b0100, 32'h0003_0000, 32'hAAFF_AAAA, 2, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
